// File: rtl/rgb_to_ycbcr_seq_ctrl.sv
// Phase sequencer for the shared RGB->YCbCr multiply-accumulate datapath.
// Issues each accepted pixel as R, G, B phases and times the result strobe.
module rgb_to_ycbcr_seq_ctrl #(
    parameter int PIXEL_W    = 8,
    parameter int COEF_W     = 10,
    parameter int STAGE1_LAT = 1,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     soft_clr_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [PIXEL_W-1:0]       s_r_i,
    input  logic [PIXEL_W-1:0]       s_g_i,
    input  logic [PIXEL_W-1:0]       s_b_i,
    output logic                     mul_valid_o,
    output logic [1:0]               mul_status_o,
    output logic [PIXEL_W-1:0]       mul_pix_o,
    output logic signed [COEF_W-1:0] coef_y_o,
    output logic signed [COEF_W-1:0] coef_cb_o,
    output logic signed [COEF_W-1:0] coef_cr_o,
    output logic                     res_valid_o,
    output logic [CNT_W-1:0]         pix_cnt_o,
    output logic                     busy_o
);

    localparam int DL_DEPTH = STAGE1_LAT + 1;

    localparam logic signed [COEF_W-1:0] Y_R  = COEF_W'(77);
    localparam logic signed [COEF_W-1:0] CB_R = COEF_W'(-43);
    localparam logic signed [COEF_W-1:0] CR_R = COEF_W'(128);
    localparam logic signed [COEF_W-1:0] Y_G  = COEF_W'(150);
    localparam logic signed [COEF_W-1:0] CB_G = COEF_W'(-85);
    localparam logic signed [COEF_W-1:0] CR_G = COEF_W'(-107);
    localparam logic signed [COEF_W-1:0] Y_B  = COEF_W'(29);
    localparam logic signed [COEF_W-1:0] CB_B = COEF_W'(128);
    localparam logic signed [COEF_W-1:0] CR_B = COEF_W'(-21);

    typedef enum logic [1:0] {IDLE, PH_R, PH_G, PH_B} state_t;

    state_t                     state;
    state_t                     next_state;
    logic                       accept;
    logic [PIXEL_W-1:0]         hold_g;
    logic [PIXEL_W-1:0]         hold_b;
    logic [DL_DEPTH-1:0]        delay_line;

    logic                       nxt_valid;
    logic [1:0]                 nxt_status;
    logic [PIXEL_W-1:0]         nxt_pix;
    logic signed [COEF_W-1:0]   nxt_y;
    logic signed [COEF_W-1:0]   nxt_cb;
    logic signed [COEF_W-1:0]   nxt_cr;

    assign s_ready_o = (state == IDLE) || (state == PH_B);
    assign accept    = s_valid_i && s_ready_o && !soft_clr_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Phase outputs are precomputed from next_state so the registered copies
    // line up with the state register; the R phase takes red straight from the
    // input because it only follows an accept, so only G and B need holding.
    always_comb begin
        next_state = state;
        nxt_valid  = 1'b0;
        nxt_status = 2'd0;
        nxt_pix    = '0;
        nxt_y      = '0;
        nxt_cb     = '0;
        nxt_cr     = '0;

        case (state)
            IDLE:    if (accept) next_state = PH_R;
            PH_R:    next_state = PH_G;
            PH_G:    next_state = PH_B;
            PH_B:    next_state = accept ? PH_R : IDLE;
            default: next_state = IDLE;
        endcase
        if (soft_clr_i) next_state = IDLE;

        case (next_state)
            PH_R: begin
                nxt_valid  = 1'b1;
                nxt_status = 2'd0;
                nxt_pix    = s_r_i;
                nxt_y      = Y_R;
                nxt_cb     = CB_R;
                nxt_cr     = CR_R;
            end
            PH_G: begin
                nxt_valid  = 1'b1;
                nxt_status = 2'd1;
                nxt_pix    = hold_g;
                nxt_y      = Y_G;
                nxt_cb     = CB_G;
                nxt_cr     = CR_G;
            end
            PH_B: begin
                nxt_valid  = 1'b1;
                nxt_status = 2'd2;
                nxt_pix    = hold_b;
                nxt_y      = Y_B;
                nxt_cb     = CB_B;
                nxt_cr     = CR_B;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_g <= '0;
            hold_b <= '0;
        end else if (accept) begin
            hold_g <= s_g_i;
            hold_b <= s_b_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_o  <= 1'b0;
            mul_status_o <= 2'd0;
            mul_pix_o    <= '0;
            coef_y_o     <= '0;
            coef_cb_o    <= '0;
            coef_cr_o    <= '0;
        end else begin
            mul_valid_o  <= nxt_valid;
            mul_status_o <= nxt_status;
            mul_pix_o    <= nxt_pix;
            coef_y_o     <= nxt_y;
            coef_cb_o    <= nxt_cb;
            coef_cr_o    <= nxt_cr;
        end
    end

    // The tail of this line fires when stage 2 holds the finished B-phase sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            delay_line <= '0;
            pix_cnt_o  <= '0;
        end else if (soft_clr_i) begin
            delay_line <= '0;
            pix_cnt_o  <= '0;
        end else begin
            delay_line <= {delay_line[DL_DEPTH-2:0], state == PH_B};
            pix_cnt_o  <= pix_cnt_o + CNT_W'(res_valid_o);
        end
    end

    assign res_valid_o = delay_line[DL_DEPTH-1];
    assign busy_o      = (state != IDLE) || (|delay_line);

endmodule

// File: tb/tb_rgb_to_ycbcr_seq_ctrl.sv
// Scoreboard bench: two sequencers (stage-1 latency 1 and 3, 16-bit and 4-bit
// counters) share one stimulus stream and are checked every cycle.
module tb_rgb_to_ycbcr_seq_ctrl;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              soft_clr = 1'b0;
    logic              s_valid = 1'b0;
    logic [7:0]        s_r = '0;
    logic [7:0]        s_g = '0;
    logic [7:0]        s_b = '0;

    logic              a_ready, a_mul_valid, a_res, a_busy;
    logic [1:0]        a_status;
    logic [7:0]        a_pix;
    logic signed [9:0] a_y, a_cb, a_cr;
    logic [15:0]       a_cnt;

    logic              b_ready, b_mul_valid, b_res, b_busy;
    logic [1:0]        b_status;
    logic [7:0]        b_pix;
    logic signed [9:0] b_y, b_cb, b_cr;
    logic [3:0]        b_cnt;

    int                compared = 0;
    int                mismatched = 0;
    int                cyc = 0;
    logic [39:0]       exp_q[$];
    int                res_a_q[$];
    int                res_b_q[$];
    logic [15:0]       cnt_a = '0;
    logic [3:0]        cnt_b = '0;

    rgb_to_ycbcr_seq_ctrl #(.PIXEL_W(8), .COEF_W(10), .STAGE1_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .soft_clr_i(soft_clr), .s_valid_i(s_valid),
        .s_ready_o(a_ready), .s_r_i(s_r), .s_g_i(s_g), .s_b_i(s_b),
        .mul_valid_o(a_mul_valid), .mul_status_o(a_status), .mul_pix_o(a_pix),
        .coef_y_o(a_y), .coef_cb_o(a_cb), .coef_cr_o(a_cr),
        .res_valid_o(a_res), .pix_cnt_o(a_cnt), .busy_o(a_busy)
    );

    rgb_to_ycbcr_seq_ctrl #(.PIXEL_W(8), .COEF_W(10), .STAGE1_LAT(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .soft_clr_i(soft_clr), .s_valid_i(s_valid),
        .s_ready_o(b_ready), .s_r_i(s_r), .s_g_i(s_g), .s_b_i(s_b),
        .mul_valid_o(b_mul_valid), .mul_status_o(b_status), .mul_pix_o(b_pix),
        .coef_y_o(b_y), .coef_cb_o(b_cb), .coef_cr_o(b_cr),
        .res_valid_o(b_res), .pix_cnt_o(b_cnt), .busy_o(b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [29:0] coef_for(input logic [1:0] st);
        case (st)
            2'd0:    return {10'sd77, -10'sd43, 10'sd128};
            2'd1:    return {10'sd150, -10'sd85, -10'sd107};
            2'd2:    return {10'sd29, 10'sd128, -10'sd21};
            default: return 30'd0;
        endcase
    endfunction

    task automatic flush_model();
        exp_q.delete();
        res_a_q.delete();
        res_b_q.delete();
        cnt_a = '0;
        cnt_b = '0;
    endtask

    // Every falling edge: pop the expected phase (or expect idle), then check
    // result strobes, busy and counters against the per-instance schedules.
    always @(negedge clk) begin
        logic [39:0] e;
        logic        exp_valid, exp_ready, exp_busy_a, exp_busy_b, exp_res_a, exp_res_b;
        exp_valid = exp_q.size() > 0;
        e = exp_valid ? exp_q.pop_front() : 40'd0;
        exp_ready = !exp_valid || (e[39:38] == 2'd2);
        checkOutput("mul_a", {a_mul_valid, a_status, a_pix, a_y, a_cb, a_cr}, {exp_valid, e});
        checkOutput("mul_b", {b_mul_valid, b_status, b_pix, b_y, b_cb, b_cr}, {exp_valid, e});
        checkOutput("ready_a", a_ready, exp_ready);
        checkOutput("ready_b", b_ready, exp_ready);
        exp_busy_a = exp_valid || (res_a_q.size() > 0);
        exp_busy_b = exp_valid || (res_b_q.size() > 0);
        checkOutput("busy_a", a_busy, exp_busy_a);
        checkOutput("busy_b", b_busy, exp_busy_b);
        if (exp_valid && e[39:38] == 2'd2) begin
            res_a_q.push_back(cyc + 2);
            res_b_q.push_back(cyc + 4);
        end
        exp_res_a = (res_a_q.size() > 0) && (res_a_q[0] == cyc);
        exp_res_b = (res_b_q.size() > 0) && (res_b_q[0] == cyc);
        if (exp_res_a) void'(res_a_q.pop_front());
        if (exp_res_b) void'(res_b_q.pop_front());
        checkOutput("res_a", a_res, exp_res_a);
        checkOutput("res_b", b_res, exp_res_b);
        checkOutput("cnt_a", a_cnt, cnt_a);
        checkOutput("cnt_b", b_cnt, cnt_b);
        cnt_a = cnt_a + 16'(exp_res_a);
        cnt_b = cnt_b + 4'(exp_res_b);
    end

    // Presents a pixel and holds it until the controller is ready; the accept
    // happens on the rising edge after this returns.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            #1;
            s_valid = 1'b1;
            s_r = r;
            s_g = g;
            s_b = b;
            if (a_ready) begin
                exp_q.push_back({2'd0, r, coef_for(2'd0)});
                exp_q.push_back({2'd1, g, coef_for(2'd1)});
                exp_q.push_back({2'd2, b, coef_for(2'd2)});
                return;
            end
        end
        checkOutput("ready_timeout", 64'd0, 64'd1);
        s_valid = 1'b0;
    endtask

    task automatic go_idle(input int n);
        @(negedge clk);
        #1;
        s_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("reset_cnt", a_cnt, 16'd0);
        checkOutput("reset_ready", a_ready, 1'b1);

        // single pixel, latency-1 instance counts it two cycles after PH_B
        applyStimulus(8'd10, 8'd20, 8'd30);
        go_idle(6);
        checkOutput("single_cnt", a_cnt, 16'd1);

        // back-to-back stream of four pixels
        for (int i = 0; i < 4; i++) applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        go_idle(8);
        checkOutput("stream_cnt", a_cnt, 16'd5);

        // soft clear while idle with a pending valid: nothing accepted, counters cleared
        @(negedge clk);
        #1;
        s_valid = 1'b1;
        soft_clr = 1'b1;
        flush_model();
        @(negedge clk);
        #1;
        soft_clr = 1'b0;
        s_valid = 1'b0;
        checkOutput("clr_idle_cnt", a_cnt, 16'd0);

        // soft clear during PH_G with valid held high
        applyStimulus(8'd55, 8'd66, 8'd77);
        @(negedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
        #1;
        s_valid = 1'b1;
        soft_clr = 1'b1;
        flush_model();
        @(negedge clk);
        #1;
        soft_clr = 1'b0;
        s_valid = 1'b0;
        checkOutput("clr_phg_busy", a_busy, 1'b0);
        checkOutput("clr_phg_valid", a_mul_valid, 1'b0);
        go_idle(6);

        // asynchronous reset in the middle of PH_R
        applyStimulus(8'd1, 8'd2, 8'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        s_valid = 1'b0;
        flush_model();
        #1;
        checkOutput("async_rst_a", {a_mul_valid, a_status, a_pix, a_y, a_cb, a_cr, a_res, a_busy, a_cnt}, 64'd0);
        checkOutput("async_rst_b", {b_mul_valid, b_status, b_pix, b_y, b_cb, b_cr, b_res, b_busy, b_cnt}, 64'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_rst_ready", a_ready, 1'b1);

        // sixteen pixels wrap the 4-bit counter back to zero
        for (int i = 0; i < 16; i++) applyStimulus(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        go_idle(8);
        checkOutput("wrap_cnt_b", b_cnt, 4'd0);
        checkOutput("wrap_cnt_a", a_cnt, 16'd16);

        // single pixel through the latency-3 instance
        applyStimulus(8'd200, 8'd100, 8'd50);
        go_idle(8);
        checkOutput("lat3_cnt_b", b_cnt, 4'd1);
        checkOutput("lat3_busy_b", b_busy, 1'b0);
        checkOutput("drain", 64'(exp_q.size() + res_a_q.size() + res_b_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/rgb_to_ycbcr_seq_ctrl.md
Name: rgb_to_ycbcr_seq_ctrl

Overview:
Sequencer for the time-multiplexed RGB-to-YCbCr multiply-accumulate datapath. It accepts one 8-bit RGB pixel per handshake and issues it to the shared stage-1 multipliers over three consecutive phases (R, G, B). Each phase carries the matching Q8 coefficient triplet plus valid/status tags for the stage-2 accumulator. It also generates the result strobe and pixel count, timed to when the stage-2 accumulators hold the finished Y/Cb/Cr sums.

Parameters:
PIXEL_W, 8, width of each colour component.
COEF_W, 10, signed coefficient width (Q8, i.e. value x 256).
STAGE1_LAT, 1, stage-1 multiplier latency in cycles (1..4).
CNT_W, 16, width of the pixel counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
soft_clr_i  in  1  synchronous abort/flush, active high.
s_valid_i  in  1  input pixel valid.
s_ready_o  out  1  controller can accept a pixel this cycle.
s_r_i / s_g_i / s_b_i  in  PIXEL_W each  input pixel components.
mul_valid_o  out  1  phase data valid to stage 1.
mul_status_o  out  2  phase tag: 0=R (first term), 1=G, 2=B (last term).
mul_pix_o  out  PIXEL_W  component selected for the current phase.
coef_y_o / coef_cb_o / coef_cr_o  out  COEF_W signed each  coefficients for the current phase.
res_valid_o  out  1  one-cycle pulse: stage-2 outputs hold a completed pixel.
pix_cnt_o  out  CNT_W  count of completed pixels.
busy_o  out  1  a pixel is in a phase or in the result delay line.

Behaviour:
- FSM states: IDLE, PH_R, PH_G, PH_B. Reset and soft_clr_i force IDLE.
- s_ready_o = (state==IDLE) or (state==PH_B), combinational from state only.
- Accept occurs when s_valid_i && s_ready_o. On accept, latch R/G/B into a holding register and go to PH_R next cycle.
- Transitions: PH_R->PH_G->PH_B unconditionally. PH_B goes to PH_R on accept, otherwise to IDLE. Sustained throughput is 1 pixel per 3 cycles with no bubble.
- All mul_* outputs are registered and update with the state:
  - mul_valid_o=1 in PH_*, 0 in IDLE.
  - mul_status_o = 0/1/2 for PH_R/G/B, and 0 in IDLE.
  - mul_pix_o = latched R/G/B per phase, 0 in IDLE.
- Coefficients (Q8), all 0 in IDLE:
  - PH_R: Y=77, Cb=-43, Cr=128.
  - PH_G: Y=150, Cb=-85, Cr=-107.
  - PH_B: Y=29, Cb=128, Cr=-21.
- Latency: first accept-to-mul_valid_o is 1 cycle.
- Result delay line: a shift register of depth STAGE1_LAT+1, fed with (state==PH_B). Its tail is res_valid_o, so the pulse arrives exactly when the stage-2 registers hold the B-phase sum.
- pix_cnt_o increments on each res_valid_o. It wraps 2^CNT_W-1 -> 0 silently.
- busy_o = (state!=IDLE) or (any delay-line bit set).
- soft_clr_i has priority over accept. In that cycle:
  - s_ready_o is still driven from state, but the accept is discarded.
  - The delay line and pix_cnt_o clear.
  - The next cycle shows mul_valid_o=0.
- Async reset mid-phase: all outputs go to 0 immediately and the FSM goes to IDLE.
- s_valid_i while not ready: no effect; the source must hold its data.

Test Plan:
1. Reset release, then a single pixel R=10,G=20,B=30 with STAGE1_LAT=1 -> mul_valid_o high for 3 cycles. status 0,1,2; mul_pix 10,20,30; coef_y 77,150,29. res_valid_o pulses 2 cycles after PH_B; pix_cnt_o=1.
2. s_valid_i held high with 4 pixels -> no mul_valid_o gap across the 12 cycles. s_ready_o asserted only in PH_B cycles; 4 res_valid_o pulses spaced 3 cycles; pix_cnt_o=4.
3. soft_clr_i asserted during PH_G, with s_valid_i high -> next cycle is IDLE with mul_valid_o=0. No res_valid_o for that pixel; pix_cnt_o=0; busy_o=0.
4. rst_n pulsed low asynchronously mid-PH_R -> all outputs 0 before the next clk edge. After release, the state is IDLE and s_ready_o=1.
5. pix_cnt_o preset to 65535 by streaming 65535 pixels -> one more pixel wraps pix_cnt_o to 0.
6. STAGE1_LAT=3, a single pixel -> res_valid_o 4 cycles after PH_B; busy_o stays high until that pulse.
